// File: rtl/button_conditioner.sv
// Per-channel button conditioner: polarity fix, 2-flop synchroniser and debounce FSM
// producing a clean level plus one-cycle press/release pulses.
//
// state          | meaning
// ---------------+------------------------------------------------------
// S_RELEASED     | accepted released, waiting for a pressed sample
// S_PRESS_WAIT   | pressed seen, counting stable cycles before accepting
// S_PRESSED      | accepted pressed, waiting for a released sample
// S_RELEASE_WAIT | released seen, counting stable cycles before accepting
module button_conditioner #(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_BUTTONS-1:0] btn_i,
  output logic [NUM_BUTTONS-1:0] level_o,
  output logic [NUM_BUTTONS-1:0] press_o,
  output logic [NUM_BUTTONS-1:0] release_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic [NUM_BUTTONS-1:0] btn_norm;
  logic [NUM_BUTTONS-1:0] sync_s1;
  logic [NUM_BUTTONS-1:0] sync_s2;

  assign btn_norm = btn_i ^ {NUM_BUTTONS{ACTIVE_LOW}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= btn_norm;
      sync_s2 <= sync_s1;
    end
  end

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             press_q;
    logic             release_q;

    // Counter is cleared on every state change, so it never needs to wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= S_RELEASED;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state_q)
          S_RELEASED: begin
            if (sync_s2[g]) begin
              state_q <= S_PRESS_WAIT;
              cnt_q   <= '0;
            end
          end
          S_PRESS_WAIT: begin
            if (!sync_s2[g]) begin
              state_q <= S_RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= S_PRESSED;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_PRESSED: begin
            if (!sync_s2[g]) begin
              state_q <= S_RELEASE_WAIT;
              cnt_q   <= '0;
            end
          end
          S_RELEASE_WAIT: begin
            if (sync_s2[g]) begin
              state_q <= S_PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q   <= S_RELEASED;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign level_o[g]   = level_q;
    assign press_o[g]   = press_q;
    assign release_o[g] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed latency/bounce/reset/polarity scenarios
// plus randomized button activity checked against a stable-run-length reference model.
module tb_button_conditioner;

  localparam int DEB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] btn;
  logic [2:0] level, press, rel;
  logic [0:0] btn_hi;
  logic [0:0] level_hi, press_hi, rel_hi;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(.NUM_BUTTONS(3), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn),
    .level_o(level), .press_o(press), .release_o(rel)
  );

  button_conditioner #(.NUM_BUTTONS(1), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk_i(clk), .rst_ni(rst_n), .btn_i(btn_hi),
    .level_o(level_hi), .press_o(press_hi), .release_o(rel_hi)
  );

  always #20 clk = ~clk;

  // Reference model: a change is accepted once the synchronised value has
  // differed from the accepted level for DEB+1 consecutive clock samples.
  logic [2:0] m_s1, m_s2, m_level, m_press, m_rel;
  int         m_run [3];

  always @(posedge clk or negedge rst_n) begin : model_step
    logic [2:0] lvl, pr, rl;
    int         run [3];
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0; m_press <= '0; m_rel <= '0;
      for (int c = 0; c < 3; c++) m_run[c] <= 0;
    end else begin
      lvl = m_level; pr = '0; rl = '0;
      for (int c = 0; c < 3; c++) begin
        run[c] = (m_s2[c] != lvl[c]) ? m_run[c] + 1 : 0;
        if (run[c] == DEB + 1) begin
          lvl[c] = ~lvl[c];
          if (lvl[c]) pr[c] = 1'b1; else rl[c] = 1'b1;
          run[c] = 0;
        end
      end
      m_level <= lvl; m_press <= pr; m_rel <= rl; m_run <= run;
      m_s2 <= m_s1;
      m_s1 <= ~btn;
    end
  end

  task automatic test_reset();
    n_checks++;
    if ({level, press, rel} !== 9'b0) begin
      n_fail++; $display("FAIL reset_hold: outs=%b expected 0", {level, press, rel});
    end
    n_checks++;
    if ({level_hi, press_hi, rel_hi} !== 3'b0) begin
      n_fail++; $display("FAIL reset_hold_hi: outs=%b expected 0", {level_hi, press_hi, rel_hi});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({level, press, rel} !== 9'b0) begin
        n_fail++; $display("FAIL reset_idle cyc %0d: outs=%b expected 0", i, {level, press, rel});
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] ep, el;
    btn[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ep = (i == 11) ? 3'b001 : 3'b000;
      el = (i >= 11) ? 3'b001 : 3'b000;
      n_checks++;
      if (press !== ep || level !== el || rel !== 3'b000) begin
        n_fail++;
        $display("FAIL clean_press cyc %0d: press=%b level=%b rel=%b expected press=%b level=%b rel=000",
                 i, press, level, rel, ep, el);
      end
    end
    btn[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ep = (i == 11) ? 3'b001 : 3'b000;
      el = (i >= 11) ? 3'b000 : 3'b001;
      n_checks++;
      if (rel !== ep || level !== el || press !== 3'b000) begin
        n_fail++;
        $display("FAIL clean_release cyc %0d: rel=%b level=%b press=%b expected rel=%b level=%b press=000",
                 i, rel, level, press, ep, el);
      end
    end
  endtask

  task automatic test_bounce();
    logic [2:0] ep, el;
    for (int i = 0; i < 7; i++) begin
      btn[1] = (i < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_checks++;
      if (press !== 3'b000 || level !== 3'b000) begin
        n_fail++; $display("FAIL bounce_quiet cyc %0d: press=%b level=%b expected 000/000", i, press, level);
      end
    end
    btn[1] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ep = (i == 11) ? 3'b010 : 3'b000;
      el = (i >= 11) ? 3'b010 : 3'b000;
      n_checks++;
      if (press !== ep || level !== el) begin
        n_fail++;
        $display("FAIL bounce_settle cyc %0d: press=%b level=%b expected press=%b level=%b", i, press, level, ep, el);
      end
    end
  endtask

  task automatic test_release();
    logic [2:0] ep, el;
    btn[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ep = (i == 11) ? 3'b010 : 3'b000;
      el = (i >= 11) ? 3'b000 : 3'b010;
      n_checks++;
      if (rel !== ep || level !== el || press !== 3'b000) begin
        n_fail++;
        $display("FAIL release cyc %0d: rel=%b level=%b press=%b expected rel=%b level=%b", i, rel, level, press, ep, el);
      end
    end
    btn[1] = 1'b0;
    repeat (12) @(negedge clk);
    btn[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn[1] = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      n_checks++;
      if (rel !== 3'b000 || level !== 3'b010) begin
        n_fail++; $display("FAIL release_glitch cyc %0d: rel=%b level=%b expected 000/010", i, rel, level);
      end
    end
    btn[1] = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [2:0] ep;
    btn = 3'b010;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ep = (i == 11) ? 3'b101 : 3'b000;
      n_checks++;
      if (press !== ep) begin
        n_fail++; $display("FAIL simultaneous cyc %0d: press=%b expected %b", i, press, ep);
      end
    end
    btn = 3'b111;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      ep = (i == 11) ? 3'b101 : 3'b000;
      n_checks++;
      if (rel !== ep || press !== 3'b000) begin
        n_fail++; $display("FAIL simultaneous_rel cyc %0d: rel=%b press=%b expected %b/000", i, rel, press, ep);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] ep, el;
    btn[2] = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (level !== 3'b100) begin
      n_fail++; $display("FAIL reset_mid_pre: level=%b expected 100", level);
    end
    btn[0] = 1'b0;
    repeat (7) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({level, press, rel} !== 9'b0) begin
      n_fail++; $display("FAIL reset_async: outs=%b expected 0", {level, press, rel});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({level, press, rel} !== 9'b0) begin
        n_fail++; $display("FAIL reset_held cyc %0d: outs=%b expected 0", i, {level, press, rel});
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      ep = (i == 11) ? 3'b101 : 3'b000;
      el = (i >= 11) ? 3'b101 : 3'b000;
      n_checks++;
      if (press !== ep || level !== el) begin
        n_fail++;
        $display("FAIL reset_fresh_press cyc %0d: press=%b level=%b expected press=%b level=%b", i, press, level, ep, el);
      end
    end
    btn = 3'b111;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_polarity();
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({level_hi, press_hi, rel_hi} !== 3'b0) begin
        n_fail++; $display("FAIL polarity_idle cyc %0d: outs=%b expected 000", i, {level_hi, press_hi, rel_hi});
      end
    end
    btn_hi = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (press_hi !== 1'(i == 11) || level_hi !== 1'(i >= 11)) begin
        n_fail++;
        $display("FAIL polarity_press cyc %0d: press=%b level=%b expected %b/%b", i, press_hi, level_hi, i == 11, i >= 11);
      end
    end
    btn_hi = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (rel_hi !== 1'(i == 11) || level_hi !== 1'(i < 11)) begin
        n_fail++;
        $display("FAIL polarity_release cyc %0d: rel=%b level=%b expected %b/%b", i, rel_hi, level_hi, i == 11, i < 11);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 900; i++) begin
      if (hold == 0) begin
        btn  = 3'($urandom);
        hold = $urandom_range(1, 14);
      end
      hold--;
      @(negedge clk);
      n_checks++;
      if (level !== m_level || press !== m_press || rel !== m_rel) begin
        n_fail++;
        $display("FAIL random cyc %0d: level=%b press=%b rel=%b expected level=%b press=%b rel=%b",
                 i, level, press, rel, m_level, m_press, m_rel);
      end
      n_checks++;
      if ((press & rel) !== 3'b000) begin
        n_fail++; $display("FAIL random_exclusive cyc %0d: press=%b rel=%b overlap", i, press, rel);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    btn    = 3'b111;
    btn_hi = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_polarity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
